// File: rtl/pc8001_clk_pkg.sv
// Shared clocking/reset definitions for the PC-8001 system clock block.
package pc8001_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        PERIPH    = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    localparam int unsigned LOCK_STABLE_DEF   = 4096;
    localparam int unsigned CPU_HOLD_DEF      = 64;
    localparam int unsigned DOT_DIV_DEF       = 2;
    localparam int unsigned CPU_DIV_DEF       = 7;
    localparam int unsigned CPU_DIV_TURBO_DEF = 4;

    localparam int unsigned F_CLK_HZ = 28636363;
    localparam int unsigned F_DOT_HZ = 14318181;
    localparam int unsigned F_CPU_HZ = 4090909;

    // States in which the dot clock enable runs.
    function automatic logic seq_active(input seq_state_e s);
        return (s == PERIPH) || (s == RUN);
    endfunction

endpackage

// File: rtl/ce_divider.sv
// Single-cycle clock-enable generator; the period is latched only while idle
// or at a wrap, so a change of div never produces a runt or stretched period.
module ce_divider #(
    parameter int unsigned MAX_DIV = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [$clog2(MAX_DIV + 1)-1:0]   div,
    output logic                             pulse
);

    localparam int unsigned DW = $clog2(MAX_DIV + 1);
    localparam int unsigned CW = $clog2(MAX_DIV);

    logic [CW-1:0] cnt;
    logic [DW-1:0] period;
    logic [DW-1:0] div_lim;
    logic          wrap;

    // Keep the period within 2..MAX_DIV so the counter can never overrun.
    always_comb begin
        div_lim = div;
        if (div < DW'(2)) begin
            div_lim = DW'(2);
        end else if (div > DW'(MAX_DIV)) begin
            div_lim = DW'(MAX_DIV);
        end
    end

    assign wrap = (DW'(cnt) >= (period - DW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            period <= DW'(MAX_DIV);
            pulse  <= 1'b0;
        end else if (!en) begin
            cnt    <= '0;
            period <= div_lim;
            pulse  <= 1'b0;
        end else if (wrap) begin
            cnt    <= '0;
            period <= div_lim;
            pulse  <= 1'b1;
        end else begin
            cnt    <= cnt + CW'(1);
            pulse  <= 1'b0;
        end
    end

endmodule

// File: rtl/pll_reset_ceg.sv
// Post-PLL reset sequencer (peripherals, then CPU) and dot/CPU clock-enable
// generation for the 28.636363 MHz system clock domain.
module pll_reset_ceg
    import pc8001_clk_pkg::*;
#(
    parameter int unsigned LOCK_STABLE   = LOCK_STABLE_DEF,
    parameter int unsigned CPU_HOLD      = CPU_HOLD_DEF,
    parameter int unsigned DOT_DIV       = DOT_DIV_DEF,
    parameter int unsigned CPU_DIV       = CPU_DIV_DEF,
    parameter int unsigned CPU_DIV_TURBO = CPU_DIV_TURBO_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_reset,
    input  logic       turbo,
    output logic       periph_rst_n,
    output logic       cpu_rst_n,
    output logic       ce_dot,
    output logic       ce_cpu,
    output logic [1:0] seq_state
);

    localparam int unsigned SW      = $clog2(LOCK_STABLE);
    localparam int unsigned HW      = $clog2(CPU_HOLD);
    localparam int unsigned CPU_MAX = (CPU_DIV > CPU_DIV_TURBO) ? CPU_DIV : CPU_DIV_TURBO;
    localparam int unsigned DDW     = $clog2(DOT_DIV + 1);
    localparam int unsigned CDW     = $clog2(CPU_MAX + 1);

    logic          lk_meta;
    logic          lk;
    seq_state_e    state;
    seq_state_e    state_nx;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_nx;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nx;
    logic          periph_nx;
    logic          cpu_nx;
    logic          dot_en;
    logic          cpu_en;
    logic [CDW-1:0] cpu_div;

    // Two-flop synchronizer for the asynchronous PLL lock indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta <= 1'b0;
            lk      <= 1'b0;
        end else begin
            lk_meta <= pll_locked;
            lk      <= lk_meta;
        end
    end

    // Next-state and next-output logic for the reset sequencer.
    always_comb begin
        state_nx  = state;
        stable_nx = stable_cnt;
        hold_nx   = hold_cnt;
        periph_nx = periph_rst_n;
        cpu_nx    = cpu_rst_n;
        if ((state != WAIT_LOCK) && !lk) begin
            state_nx  = WAIT_LOCK;
            stable_nx = '0;
            hold_nx   = '0;
            periph_nx = 1'b0;
            cpu_nx    = 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    stable_nx = '0;
                    hold_nx   = '0;
                    periph_nx = 1'b0;
                    cpu_nx    = 1'b0;
                    if (lk) state_nx = SETTLE;
                end
                SETTLE: begin
                    if (stable_cnt == SW'(LOCK_STABLE - 1)) begin
                        state_nx  = PERIPH;
                        hold_nx   = '0;
                        periph_nx = 1'b1;
                    end else begin
                        stable_nx = stable_cnt + SW'(1);
                    end
                end
                PERIPH: begin
                    if (hold_cnt == HW'(CPU_HOLD - 1)) begin
                        state_nx = RUN;
                        cpu_nx   = 1'b1;
                    end else begin
                        hold_nx = hold_cnt + HW'(1);
                    end
                end
                RUN: begin
                    if (soft_reset) begin
                        state_nx = PERIPH;
                        hold_nx  = '0;
                        cpu_nx   = 1'b0;
                    end
                end
                default: begin
                    state_nx  = WAIT_LOCK;
                    periph_nx = 1'b0;
                    cpu_nx    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_LOCK;
            stable_cnt   <= '0;
            hold_cnt     <= '0;
            periph_rst_n <= 1'b0;
            cpu_rst_n    <= 1'b0;
        end else begin
            state        <= state_nx;
            stable_cnt   <= stable_nx;
            hold_cnt     <= hold_nx;
            periph_rst_n <= periph_nx;
            cpu_rst_n    <= cpu_nx;
        end
    end

    // Enables drop on the same edge that leaves their active states.
    assign dot_en  = seq_active(state) && seq_active(state_nx);
    assign cpu_en  = (state == RUN) && (state_nx == RUN);
    assign cpu_div = turbo ? CDW'(CPU_DIV_TURBO) : CDW'(CPU_DIV);

    ce_divider #(.MAX_DIV(DOT_DIV)) u_dot_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dot_en),
        .div   (DDW'(DOT_DIV)),
        .pulse (ce_dot)
    );

    ce_divider #(.MAX_DIV(CPU_MAX)) u_cpu_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cpu_en),
        .div   (cpu_div),
        .pulse (ce_cpu)
    );

    assign seq_state = state;

endmodule
